// File: rtl/best_move_select_if.sv
// best_move_select_if: request, move-list read and result signals between the selector and its environment.
interface best_move_select_if #(
  parameter int MAX_POSITIONS_LOG2 = 8,
  parameter int EVAL_WIDTH = 24,
  parameter int UCI_WIDTH = 16
);
  logic start, white_to_move, am_moves_ready, initial_mate, initial_stalemate;
  logic [MAX_POSITIONS_LOG2-1:0] am_move_count, am_move_index, best_index;
  logic signed [EVAL_WIDTH-1:0] eval_in, best_eval;
  logic [UCI_WIDTH-1:0] uci_in, best_uci;
  logic am_clear_moves, busy, done, best_valid, mate_out, stalemate_out;
  modport master (
    output start, white_to_move, am_moves_ready, am_move_count, initial_mate, initial_stalemate, eval_in, uci_in,
    input am_move_index, am_clear_moves, busy, done, best_valid, best_index, best_eval, best_uci, mate_out, stalemate_out
  );
  modport slave (
    input start, white_to_move, am_moves_ready, am_move_count, initial_mate, initial_stalemate, eval_in, uci_in,
    output am_move_index, am_clear_moves, busy, done, best_valid, best_index, best_eval, best_uci, mate_out, stalemate_out
  );
endinterface

// File: rtl/best_move_select.sv
// best_move_select: scans the generated move list and keeps the best eval for the side to move.
module best_move_select #(
  parameter int MAX_POSITIONS_LOG2 = 8,
  parameter int EVAL_WIDTH = 24,
  parameter int UCI_WIDTH = 16,
  parameter int READ_LATENCY = 2
) (
  input logic clk,
  input logic reset,
  best_move_select_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WAIT_READY, FETCH, COMPARE, CLEAR, DONE} state_t;
  localparam int CW = READ_LATENCY < 2 ? 1 : $clog2(READ_LATENCY);
  localparam logic [CW-1:0] LAST = CW'(READ_LATENCY - 1);
  localparam logic [MAX_POSITIONS_LOG2:0] ONE = 1;
  state_t state;
  logic white, more, better;
  logic [MAX_POSITIONS_LOG2-1:0] count;
  logic [CW-1:0] wait_cnt;
  // one extra bit so a full-size list never wraps the end test
  assign more = ({1'b0, bus.am_move_index} + ONE) < {1'b0, count};
  assign better = white ? bus.eval_in > bus.best_eval : bus.eval_in < bus.best_eval;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      white <= 1'b0;
      count <= '0;
      wait_cnt <= '0;
      bus.am_move_index <= '0;
      bus.am_clear_moves <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.best_valid <= 1'b0;
      bus.best_index <= '0;
      bus.best_eval <= '0;
      bus.best_uci <= '0;
      bus.mate_out <= 1'b0;
      bus.stalemate_out <= 1'b0;
    end else begin
      bus.am_clear_moves <= 1'b0;
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          white <= bus.white_to_move;
          bus.busy <= 1'b1;
          bus.best_valid <= 1'b0;
          bus.mate_out <= 1'b0;
          bus.stalemate_out <= 1'b0;
          state <= WAIT_READY;
        end
        WAIT_READY: if (bus.am_moves_ready) begin
          count <= bus.am_move_count;
          if (bus.am_move_count == '0) begin
            bus.mate_out <= bus.initial_mate;
            bus.stalemate_out <= bus.initial_stalemate;
            bus.best_valid <= 1'b0;
            bus.best_eval <= '0;
            bus.best_uci <= '0;
            bus.best_index <= '0;
            bus.am_clear_moves <= 1'b1;
            state <= CLEAR;
          end else begin
            bus.am_move_index <= '0;
            wait_cnt <= '0;
            state <= FETCH;
          end
        end
        FETCH: if (wait_cnt == LAST) state <= COMPARE; else wait_cnt <= wait_cnt + CW'(1);
        COMPARE: begin
          if (bus.am_move_index == '0 || better) begin
            bus.best_eval <= bus.eval_in;
            bus.best_uci <= bus.uci_in;
            bus.best_index <= bus.am_move_index;
            bus.best_valid <= 1'b1;
          end
          if (more) begin
            bus.am_move_index <= bus.am_move_index + MAX_POSITIONS_LOG2'(1);
            wait_cnt <= '0;
            state <= FETCH;
          end else begin
            bus.am_clear_moves <= 1'b1;
            state <= CLEAR;
          end
        end
        CLEAR: begin
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_best_move_select.sv
// tb_best_move_select: randomized and directed checks of best_move_select against a list-scan reference.
module tb_best_move_select;
  localparam int M = 8, E = 24, U = 16, L = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int compared = 0;
  int mismatched = 0;
  logic signed [E-1:0] mem_eval [256];
  logic [U-1:0] mem_uci [256];
  logic [M-1:0] pipe [L];
  best_move_select_if #(.MAX_POSITIONS_LOG2(M), .EVAL_WIDTH(E), .UCI_WIDTH(U)) bus();
  best_move_select #(.MAX_POSITIONS_LOG2(M), .EVAL_WIDTH(E), .UCI_WIDTH(U), .READ_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  // move RAM with L cycles from address change to data
  always @(posedge clk) begin
    cyc <= cyc + 1;
    pipe[0] <= bus.am_move_index;
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.eval_in = mem_eval[pipe[L-1]];
  assign bus.uci_in = mem_uci[pipe[L-1]];

  function automatic int ref_best(input bit w, input int n);
    int b = 0;
    for (int k = 1; k < n; k++)
      if (w ? mem_eval[k] > mem_eval[b] : mem_eval[k] < mem_eval[b]) b = k;
    return b;
  endfunction

  task automatic load(input int n, input int e0, input int e1, input int e2);
    int e[3] = '{e0, e1, e2};
    for (int k = 0; k < n; k++) begin
      mem_eval[k] = E'(e[k]);
      mem_uci[k] = U'($urandom);
    end
  endtask

  task automatic run_sel(input bit w, input int n, input bit m, input bit s, input int gap, input int restart_at,
                         output int rc, output int clr_at, output int done_at, output int clr_n, output int busy_err);
    @(negedge clk);
    bus.start = 1'b1; bus.white_to_move = w; bus.am_move_count = M'(n);
    bus.initial_mate = m; bus.initial_stalemate = s;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (gap) @(negedge clk);
    bus.am_moves_ready = 1'b1;
    rc = cyc; clr_at = -1; done_at = -1; clr_n = 0; busy_err = 0;
    for (int i = 0; i < 200 && done_at < 0; i++) begin
      bus.start = (i == restart_at);
      bus.white_to_move = (i == restart_at) ? ~w : w;
      @(negedge clk);
      if (bus.am_clear_moves) begin clr_n++; clr_at = cyc; bus.am_moves_ready = 1'b0; end
      if (bus.done) begin done_at = cyc; if (bus.busy) busy_err++; end
      else if (!bus.busy) busy_err++;
    end
    bus.start = 1'b0;
    bus.am_moves_ready = 1'b0;
  endtask

  task automatic test_reset;
    bus.start = 1'b0; bus.white_to_move = 1'b0; bus.am_moves_ready = 1'b0; bus.am_move_count = '0;
    bus.initial_mate = 1'b0; bus.initial_stalemate = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    compared++;
    if ({bus.busy, bus.done, bus.am_clear_moves, bus.best_valid, bus.mate_out, bus.stalemate_out,
         bus.am_move_index, bus.best_index, bus.best_eval, bus.best_uci} !== 62'd0) begin
      mismatched++; $display("FAIL reset_outputs: busy=%b done=%b idx=%0d best=%0d", bus.busy, bus.done, bus.am_move_index, bus.best_index);
    end
    reset = 1'b0;
  endtask

  task automatic test_white_max;
    int rc, ca, da, cn, be;
    load(3, 10, -5, 40);
    run_sel(1'b1, 3, 1'b0, 1'b0, 2, -1, rc, ca, da, cn, be);
    compared += 5;
    if (bus.best_index !== 8'd2 || bus.best_valid !== 1'b1) begin mismatched++; $display("FAIL white_index: got %0d valid %b, want 2 valid 1", bus.best_index, bus.best_valid); end
    if (bus.best_eval !== 24'sd40) begin mismatched++; $display("FAIL white_eval: got %0d want 40", bus.best_eval); end
    if (bus.best_uci !== mem_uci[2]) begin mismatched++; $display("FAIL white_uci: got %h want %h", bus.best_uci, mem_uci[2]); end
    if (ca !== rc + 10 || cn !== 1) begin mismatched++; $display("FAIL white_clear: got r+%0d x%0d want r+10 x1", ca - rc, cn); end
    if (da !== rc + 11 || be !== 0) begin mismatched++; $display("FAIL white_done: got r+%0d busy_err %0d want r+11 0", da - rc, be); end
  endtask

  task automatic test_black_min;
    int rc, ca, da, cn, be;
    load(3, 10, -5, 40);
    run_sel(1'b0, 3, 1'b0, 1'b0, 0, -1, rc, ca, da, cn, be);
    compared += 3;
    if (bus.best_index !== 8'd1) begin mismatched++; $display("FAIL black_index: got %0d want 1", bus.best_index); end
    if (bus.best_eval !== -24'sd5) begin mismatched++; $display("FAIL black_eval: got %0d want -5", bus.best_eval); end
    if (bus.best_uci !== mem_uci[1]) begin mismatched++; $display("FAIL black_uci: got %h want %h", bus.best_uci, mem_uci[1]); end
  endtask

  task automatic test_ties;
    int rc, ca, da, cn, be;
    load(3, 7, 7, 3);
    run_sel(1'b1, 3, 1'b0, 1'b0, 1, -1, rc, ca, da, cn, be);
    compared++;
    if (bus.best_index !== 8'd0) begin mismatched++; $display("FAIL tie_white: got %0d want 0", bus.best_index); end
    load(3, 3, 9, 3);
    run_sel(1'b0, 3, 1'b0, 1'b0, 1, -1, rc, ca, da, cn, be);
    compared++;
    if (bus.best_index !== 8'd0) begin mismatched++; $display("FAIL tie_black: got %0d want 0", bus.best_index); end
  endtask

  task automatic test_extremes;
    int rc, ca, da, cn, be;
    load(2, -8388608, 8388607, 0);
    run_sel(1'b1, 2, 1'b0, 1'b0, 0, -1, rc, ca, da, cn, be);
    compared += 2;
    if (bus.best_index !== 8'd1) begin mismatched++; $display("FAIL ext_white_index: got %0d want 1", bus.best_index); end
    if (bus.best_eval !== 24'sd8388607) begin mismatched++; $display("FAIL ext_white_eval: got %0d want 8388607", bus.best_eval); end
    run_sel(1'b0, 2, 1'b0, 1'b0, 0, -1, rc, ca, da, cn, be);
    compared++;
    if (bus.best_index !== 8'd0 || bus.best_eval !== -24'sd8388608) begin mismatched++; $display("FAIL ext_black: got %0d/%0d want 0/-8388608", bus.best_index, bus.best_eval); end
  endtask

  task automatic test_empty_mate;
    int rc, ca, da, cn, be;
    run_sel(1'b1, 0, 1'b1, 1'b0, 3, -1, rc, ca, da, cn, be);
    compared += 4;
    if (bus.best_valid !== 1'b0 || bus.mate_out !== 1'b1 || bus.stalemate_out !== 1'b0) begin
      mismatched++; $display("FAIL empty_flags: valid %b mate %b stale %b want 0 1 0", bus.best_valid, bus.mate_out, bus.stalemate_out);
    end
    if ({bus.best_index, bus.best_eval, bus.best_uci} !== 48'd0) begin mismatched++; $display("FAIL empty_best: got %0d/%0d/%h want zeros", bus.best_index, bus.best_eval, bus.best_uci); end
    if (ca !== rc + 1 || cn !== 1) begin mismatched++; $display("FAIL empty_clear: got r+%0d x%0d want r+1 x1", ca - rc, cn); end
    if (da !== rc + 2) begin mismatched++; $display("FAIL empty_done: got r+%0d want r+2", da - rc); end
  endtask

  task automatic test_start_while_busy;
    int rc, ca, da, cn, be;
    load(3, 10, -5, 40);
    run_sel(1'b1, 3, 1'b0, 1'b0, 1, 3, rc, ca, da, cn, be);
    compared += 2;
    if (bus.best_index !== 8'd2 || bus.best_eval !== 24'sd40) begin mismatched++; $display("FAIL busy_start_result: got %0d/%0d want 2/40", bus.best_index, bus.best_eval); end
    if (da !== rc + 11 || be !== 0) begin mismatched++; $display("FAIL busy_start_done: got r+%0d busy_err %0d want r+11 0", da - rc, be); end
    @(negedge clk);
    compared++;
    if (bus.busy !== 1'b0) begin mismatched++; $display("FAIL busy_start_idle: busy %b want 0", bus.busy); end
  endtask

  task automatic test_reset_mid;
    int rc, ca, da, cn, be, pulses = 0;
    load(3, 10, -5, 40);
    @(negedge clk);
    bus.start = 1'b1; bus.white_to_move = 1'b1; bus.am_move_count = 8'd3;
    @(negedge clk);
    bus.start = 1'b0; bus.am_moves_ready = 1'b1; rc = cyc;
    while (cyc < rc + L + 2) @(negedge clk);
    compared++;
    if (bus.am_move_index !== 8'd1 || bus.best_valid !== 1'b1 || bus.busy !== 1'b1) begin
      mismatched++; $display("FAIL mid_fetch1: idx %0d valid %b busy %b want 1 1 1", bus.am_move_index, bus.best_valid, bus.busy);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; bus.am_moves_ready = 1'b0;
    compared++;
    if ({bus.busy, bus.done, bus.am_clear_moves, bus.best_valid, bus.mate_out, bus.stalemate_out,
         bus.am_move_index, bus.best_index, bus.best_eval, bus.best_uci} !== 62'd0) begin
      mismatched++; $display("FAIL mid_reset_outputs: busy=%b valid=%b idx=%0d eval=%0d", bus.busy, bus.best_valid, bus.am_move_index, bus.best_eval);
    end
    repeat (12) begin @(negedge clk); if (bus.am_clear_moves || bus.done) pulses++; end
    compared++;
    if (pulses !== 0) begin mismatched++; $display("FAIL mid_reset_pulses: got %0d want 0", pulses); end
    load(1, -77, 0, 0);
    run_sel(1'b0, 1, 1'b0, 1'b0, 0, -1, rc, ca, da, cn, be);
    compared += 2;
    if (da !== rc + (L + 1) + 2) begin mismatched++; $display("FAIL after_reset_done: got r+%0d want r+%0d", da - rc, L + 3); end
    if (bus.best_eval !== -24'sd77 || bus.best_valid !== 1'b1) begin mismatched++; $display("FAIL after_reset_best: got %0d valid %b want -77 1", bus.best_eval, bus.best_valid); end
  endtask

  task automatic test_random;
    int rc, ca, da, cn, be, n, b;
    bit w;
    for (int t = 0; t < 25; t++) begin
      n = $urandom_range(1, 12);
      w = 1'($urandom);
      for (int k = 0; k < n; k++) begin
        mem_eval[k] = (t % 2 == 0) ? E'($urandom) : E'(int'($urandom_range(0, 4)) - 2);
        mem_uci[k] = U'($urandom);
      end
      b = ref_best(w, n);
      run_sel(w, n, 1'b0, 1'b0, $urandom_range(0, 3), -1, rc, ca, da, cn, be);
      compared += 3;
      if (bus.best_index !== M'(b) || bus.best_valid !== 1'b1) begin mismatched++; $display("FAIL rand_index t%0d: got %0d want %0d", t, bus.best_index, b); end
      if (bus.best_eval !== mem_eval[b] || bus.best_uci !== mem_uci[b]) begin
        mismatched++; $display("FAIL rand_best t%0d: got %0d/%h want %0d/%h", t, bus.best_eval, bus.best_uci, mem_eval[b], mem_uci[b]);
      end
      if (ca !== rc + n * (L + 1) + 1 || da !== rc + n * (L + 1) + 2 || cn !== 1 || be !== 0) begin
        mismatched++; $display("FAIL rand_timing t%0d: clear r+%0d done r+%0d n=%0d", t, ca - rc, da - rc, n);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_white_max;
    test_black_min;
    test_ties;
    test_extremes;
    test_empty_mate;
    test_start_while_busy;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
